dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- Parametrised true dual-port RAM, successor to the plain dual-port RAM in the GameBoy simulator.
- Adds per-byte write enables and a selectable read latency of 0, 1 or 2 cycles with a valid strobe.
- Adds deterministic same-address write-collision resolution with a collision flag, and an optional hardware clear sweep after reset.
- Used for VRAM/WRAM/OAM-style stores where CPU and video/DMA ports share one clock.

Parameters:
- addr_width, 10, word address bits; depth = 2**addr_width.
- data_width, 16, word width; must be a multiple of 8; nbytes = data_width/8.
- read_latency, 1, 0 = combinational read, 1 = one register, 2 = two registers.
- collision_mode, 0, 0 = port A wins overlapping bytes, 1 = port B wins.
- clear_on_reset, 1, 1 = sweep all words to zero after reset; 0 = no sweep.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- busy  out  1  clear sweep in progress; ports ignored while high.
- address_a  in  addr_width  port A word address.
- data_a  in  data_width  port A write data.
- wren_a  in  1  port A write request.
- byteena_a  in  nbytes  port A byte enables; bit i covers data[8i+7:8i].
- rden_a  in  1  port A read request.
- q_a  out  data_width  port A read data.
- q_valid_a  out  1  q_a holds the result of a read request.
- address_b, data_b, wren_b, byteena_b, rden_b, q_b, q_valid_b: same as port A, for port B.
- collision  out  1  one-cycle pulse; same-address write collision with overlapping byte enables.

Behaviour:
- Reset asserted:
  - q_a = q_b = 0; q_valid_a = q_valid_b = 0; collision = 0; all pipeline registers = 0.
  - busy = clear_on_reset. FSM enters CLEAR when clear_on_reset = 1, otherwise READY.
  - Memory contents are not reset asynchronously.
- FSM state CLEAR:
  - Counter clr_addr starts at 0. One word is written to 0 per cycle.
  - Transition to READY on the edge that writes word depth-1, so the sweep takes exactly 2**addr_width cycles after reset deassertion.
  - busy falls in the first READY cycle.
  - Port wren/rden inputs are ignored; q_valid stays 0.
  - Reset reasserted mid-sweep: clr_addr returns to 0 and the sweep restarts in full.
- FSM state READY:
  - Terminal state; left only via reset.
  - Simulation memory initialises to 0 at time zero regardless of clear_on_reset.
- Write:
  - On the rising edge with wren_x = 1 and not busy, bytes with byteena_x[i] = 1 are updated; other bytes are kept.
  - wren with byteena = 0: no change.
- Collision:
  - Occurs when wren_a, wren_b, address_a == address_b and (byteena_a & byteena_b) != 0.
  - Overlapping bytes take the winner's data per collision_mode. Non-overlapping enabled bytes from both ports are written.
  - collision is registered: high for exactly the cycle after the colliding edge.
  - Same address with disjoint byte enables: both writes merge, collision = 0.
- Read, read_latency = 0:
  - q_x = mem[address_x] combinationally. q_valid_x = rden_x & ~busy.
  - A write on edge N is visible on both ports immediately after edge N.
- Read, read_latency = 1:
  - On the edge where rden_x = 1, q_x captures the pre-write word (read-first, on both the same port and the cross port). q_valid_x = 1 for the following cycle.
  - q_x holds its value when rden_x = 0; q_valid_x then drops to 0.
- Read, read_latency = 2:
  - Stage 1 as for latency 1. Stage 2 registers data and valid again.
  - Result appears 2 cycles after the request. Back-to-back reads sustain one result per cycle.
- Address and read requests are never stalled; there is no backpressure.
- Widths: byte lanes are strictly little-endian. The collision comparator is a full addr_width equality.

Decomposition:
- Package dpram_pkg:
  - Constants COLL_A_WINS = 0 and COLL_B_WINS = 1.
  - Constants LAT_COMB = 0, LAT_REG = 1 and LAT_REG2 = 2.
  - FSM state type {CLEAR, READY}.
  - Function for nbytes.
- Sub-module dpram_read_pipe:
  - Parametrised on data_width and read_latency.
  - Inputs raw word, rden and busy; outputs q and q_valid.
  - Instantiated once per port.
- The top level holds the array, byte-lane write merge, collision logic and the clear FSM.

Test Plan:
- Clear sweep, addr_width = 4, clear_on_reset = 1, memory pre-written with 0xFFFF: deassert reset -> busy stays high for exactly 16 cycles; every address then reads 0x0000.
- Byte enables, latency 1: write A addr 0x05 data 0x1234 be 2'b11, then addr 0x05 data 0xAB00 be 2'b10 -> rden_a on addr 0x05 yields q_a = 0xAB34 with q_valid_a one cycle after the request.
- Collision, collision_mode = 0, same edge: A writes addr 0x10 data 0x1111 be 11; B writes addr 0x10 data 0x2222 be 01 -> word = 0x1111, collision high for one cycle. Repeat with B be 10 and A be 01 -> word = 0x2211, collision = 0.
- Latency 2 streaming: write addr n = n for n = 0..3, then issue rden on 0..3 in consecutive cycles -> q = 0,1,2,3 starting two cycles after the first request; q_valid high for 4 cycles.
- Read-during-write, latency 1: word 0x0000 at addr 3; A writes 0x5555 while B reads addr 3 on the same edge -> q_b = 0x0000; a read on the next cycle returns 0x5555.
- Reset mid-sweep: assert reset at clr_addr = 7 for 2 cycles -> outputs go to 0 immediately; after deassertion, busy stays high for the full 2**addr_width cycles.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enabled dual-port RAM.
// Collision policy, read latency encodings and the clear FSM state.
package dpram_pkg;

  localparam int COLL_A_WINS = 0;
  localparam int COLL_B_WINS = 1;

  localparam int LAT_COMB = 0;
  localparam int LAT_REG  = 1;
  localparam int LAT_REG2 = 2;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dpram_read_pipe.sv
// Per-port read output stage: combinational, one or two registers.
// Stage 1 holds its word between requests; stage 2 simply follows it.
module dpram_read_pipe
  import dpram_pkg::*;
#(
  parameter int data_width   = 16,
  parameter int read_latency = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [data_width-1:0] raw,
  input  logic                  rden,
  input  logic                  busy,
  output logic [data_width-1:0] q,
  output logic                  q_valid
);

  logic hit;
  assign hit = rden & ~busy;

  generate
    if (read_latency == LAT_COMB) begin : g_comb
      assign q       = raw;
      assign q_valid = hit;
    end else begin : g_reg
      logic [data_width-1:0] s1_q, s1_d;
      logic                  v1_q, v1_d;

      always_comb begin
        s1_d = s1_q;
        v1_d = hit;
        if (hit) s1_d = raw;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_q <= '0;
          v1_q <= 1'b0;
        end else begin
          s1_q <= s1_d;
          v1_q <= v1_d;
        end
      end

      if (read_latency == LAT_REG) begin : g_one
        assign q       = s1_q;
        assign q_valid = v1_q;
      end else begin : g_two
        logic [data_width-1:0] s2_q, s2_d;
        logic                  v2_q, v2_d;

        always_comb begin
          s2_d = s1_q;
          v2_d = v1_q;
        end

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            s2_q <= '0;
            v2_q <= 1'b0;
          end else begin
            s2_q <= s2_d;
            v2_q <= v2_d;
          end
        end

        assign q       = s2_q;
        assign q_valid = v2_q;
      end
    end
  endgenerate

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, collision arbitration,
// selectable read latency and an optional post-reset clear sweep.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int addr_width     = 10,
  parameter int data_width     = 16,
  parameter int read_latency   = 1,
  parameter int collision_mode = 0,
  parameter int clear_on_reset = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            busy,
  input  logic [addr_width-1:0]           address_a,
  input  logic [data_width-1:0]           data_a,
  input  logic                            wren_a,
  input  logic [nbytes(data_width)-1:0]   byteena_a,
  input  logic                            rden_a,
  output logic [data_width-1:0]           q_a,
  output logic                            q_valid_a,
  input  logic [addr_width-1:0]           address_b,
  input  logic [data_width-1:0]           data_b,
  input  logic                            wren_b,
  input  logic [nbytes(data_width)-1:0]   byteena_b,
  input  logic                            rden_b,
  output logic [data_width-1:0]           q_b,
  output logic                            q_valid_b,
  output logic                            collision
);

  localparam int NB    = nbytes(data_width);
  localparam int DEPTH = 2 ** addr_width;
  localparam logic [addr_width-1:0] LAST = '1;

  logic [data_width-1:0] mem [DEPTH];

  state_e                state_q;
  logic [addr_width-1:0] clr_addr_q;
  logic                  busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= (clear_on_reset != 0) ? CLEAR : READY;
      clr_addr_q <= '0;
      busy_q     <= (clear_on_reset != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic          same;
  logic [NB-1:0] ma, mb, overlap, ma_eff, mb_eff;
  logic          coll_d, coll_q;

  // Overlapping lanes are stripped from the losing port only.
  always_comb begin
    same    = (address_a == address_b);
    ma      = byteena_a & {NB{wren_a & ~busy_q}};
    mb      = byteena_b & {NB{wren_b & ~busy_q}};
    overlap = ma & mb & {NB{same}};
    ma_eff  = ma;
    mb_eff  = mb;
    if (collision_mode == COLL_B_WINS) ma_eff = ma & ~overlap;
    else                               mb_eff = mb & ~overlap;
    coll_d  = |overlap;
  end

  always_ff @(posedge clock) begin
    if (busy_q) begin
      mem[clr_addr_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (ma_eff[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
        if (mb_eff[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) coll_q <= 1'b0;
    else       coll_q <= coll_d;
  end

  logic [data_width-1:0] raw_a, raw_b;
  assign raw_a = mem[address_a];
  assign raw_b = mem[address_b];

  dpram_read_pipe #(
    .data_width  (data_width),
    .read_latency(read_latency)
  ) u_pipe_a (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_a),
    .rden   (rden_a),
    .busy   (busy_q),
    .q      (q_a),
    .q_valid(q_valid_a)
  );

  dpram_read_pipe #(
    .data_width  (data_width),
    .read_latency(read_latency)
  ) u_pipe_b (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_b),
    .rden   (rden_b),
    .busy   (busy_q),
    .q      (q_b),
    .q_valid(q_valid_b)
  );

  assign busy      = busy_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: latency-1 and latency-2 instances share stimulus
// and are compared every cycle against a word-level memory model.
module tb_dpram_be;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] address_a, address_b;
  logic [15:0]   data_a, data_b;
  logic          wren_a, wren_b, rden_a, rden_b;
  logic [1:0]    byteena_a, byteena_b;

  logic        l1_busy, l1_va, l1_vb, l1_coll;
  logic [15:0] l1_qa, l1_qb;
  logic        l2_busy, l2_va, l2_vb, l2_coll;
  logic [15:0] l2_qa, l2_qb;

  dpram_be #(
    .addr_width(AW), .data_width(16), .read_latency(1),
    .collision_mode(0), .clear_on_reset(1)
  ) u_l1 (
    .clock(clock), .reset(reset), .busy(l1_busy),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
    .byteena_a(byteena_a), .rden_a(rden_a),
    .q_a(l1_qa), .q_valid_a(l1_va),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b),
    .byteena_b(byteena_b), .rden_b(rden_b),
    .q_b(l1_qb), .q_valid_b(l1_vb),
    .collision(l1_coll)
  );

  dpram_be #(
    .addr_width(AW), .data_width(16), .read_latency(2),
    .collision_mode(0), .clear_on_reset(1)
  ) u_l2 (
    .clock(clock), .reset(reset), .busy(l2_busy),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
    .byteena_a(byteena_a), .rden_a(rden_a),
    .q_a(l2_qa), .q_valid_a(l2_va),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b),
    .byteena_b(byteena_b), .rden_b(rden_b),
    .q_b(l2_qb), .q_valid_b(l2_vb),
    .collision(l2_coll)
  );

  int checks = 0;
  int errors = 0;
  bit run = 0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: word array, remaining sweep count, last read per port.
  logic [15:0] mem_m [DEPTH];
  int          busy_cnt = DEPTH;
  logic [15:0] e1_qa, e1_qb, e2_qa, e2_qb, ra, rb;
  logic        e1_va, e1_vb, e2_va, e2_vb, e_coll;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    {e1_qa, e1_qb, e2_qa, e2_qb} = '0;
    {e1_va, e1_vb, e2_va, e2_vb, e_coll} = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        busy_cnt = DEPTH;
        {e1_qa, e1_qb, e2_qa, e2_qb} = '0;
        {e1_va, e1_vb, e2_va, e2_vb, e_coll} = '0;
      end else begin
        e2_qa = e1_qa; e2_va = e1_va;
        e2_qb = e1_qb; e2_vb = e1_vb;
        if (busy_cnt > 0) begin
          mem_m[DEPTH - busy_cnt] = '0;
          busy_cnt--;
          e1_va = 0; e1_vb = 0; e_coll = 0;
        end else begin
          ra = mem_m[address_a];
          rb = mem_m[address_b];
          e1_va = rden_a;
          e1_vb = rden_b;
          if (rden_a) e1_qa = ra;
          if (rden_b) e1_qb = rb;
          e_coll = wren_a && wren_b && (address_a == address_b)
                   && ((byteena_a & byteena_b) != 0);
          // B first, then A, so A owns any shared byte.
          for (int i = 0; i < 2; i++)
            if (wren_b && byteena_b[i])
              mem_m[address_b][8*i +: 8] = data_b[8*i +: 8];
          for (int i = 0; i < 2; i++)
            if (wren_a && byteena_a[i])
              mem_m[address_a][8*i +: 8] = data_a[8*i +: 8];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (run) begin
        if (reset) begin
          chk("rst_busy", {l1_busy, l2_busy}, 2'b11);
          chk("rst_q_l1", {l1_qa | l1_qb}, 16'h0);
          chk("rst_q_l2", {l2_qa | l2_qb}, 16'h0);
          chk("rst_flags", {l1_va, l1_vb, l2_va, l2_vb, l1_coll, l2_coll}, 0);
        end else begin
          chk("busy_l1", l1_busy, busy_cnt > 0);
          chk("busy_l2", l2_busy, busy_cnt > 0);
          chk("l1_q_a", l1_qa, e1_qa);
          chk("l1_v_a", l1_va, e1_va);
          chk("l1_q_b", l1_qb, e1_qb);
          chk("l1_v_b", l1_vb, e1_vb);
          chk("l2_q_a", l2_qa, e2_qa);
          chk("l2_v_a", l2_va, e2_va);
          chk("l2_q_b", l2_qb, e2_qb);
          chk("l2_v_b", l2_vb, e2_vb);
          chk("coll_l1", l1_coll, e_coll);
          chk("coll_l2", l2_coll, e_coll);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
  endtask

  task automatic wr_a(input int a, input logic [15:0] d,
                      input logic [1:0] be);
    address_a = AW'(a); data_a = d; byteena_a = be; wren_a = 1;
  endtask

  task automatic wr_b(input int a, input logic [15:0] d,
                      input logic [1:0] be);
    address_b = AW'(a); data_b = d; byteena_b = be; wren_b = 1;
  endtask

  task automatic count_busy(input string name);
    int  n    = 0;
    bit  done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clock);
      if (l1_busy) n++;
      else done = 1;
    end
    chk(name, 16'(n), 16'(DEPTH));
  endtask

  initial begin
    reset = 1;
    idle();
    address_a = '0; address_b = '0;
    data_a = '0; data_b = '0;
    byteena_a = '0; byteena_b = '0;
    tick();
    run = 1;
    tick();
    reset = 0;
    count_busy("sweep0_len");

    for (int i = 0; i < DEPTH; i++) begin
      wr_a(i, 16'hFFFF, 2'b11);
      tick();
    end
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    count_busy("sweep1_len");
    rden_a = 1;
    for (int i = 0; i < DEPTH; i++) begin
      address_a = AW'(i);
      tick();
      @(negedge clock);
      chk("clr_word", l1_qa, 16'h0000);
    end
    idle();

    wr_a(5, 16'h1234, 2'b11); tick();
    wr_a(5, 16'hAB00, 2'b10); tick();
    idle(); address_a = 5; rden_a = 1; tick(); idle();
    @(negedge clock);
    chk("be_q", l1_qa, 16'hAB34);
    chk("be_v", l1_va, 1);

    wr_a(16, 16'h1111, 2'b11);
    wr_b(16, 16'h2222, 2'b01);
    tick(); idle();
    @(negedge clock);
    chk("coll_hi", l1_coll, 1);
    tick();
    @(negedge clock);
    chk("coll_pulse", l1_coll, 0);
    address_a = 16; rden_a = 1; tick(); idle();
    @(negedge clock);
    chk("coll_word", l1_qa, 16'h1111);

    wr_a(16, 16'h1111, 2'b01);
    wr_b(16, 16'h2222, 2'b10);
    tick(); idle();
    @(negedge clock);
    chk("merge_coll", l1_coll, 0);
    address_a = 16; rden_a = 1; tick(); idle();
    @(negedge clock);
    chk("merge_word", l1_qa, 16'h2211);

    for (int n = 0; n < 4; n++) begin
      wr_a(n, 16'(n), 2'b11);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        address_a = AW'(i);
        rden_a = 1;
      end else begin
        rden_a = 0;
      end
      tick();
      @(negedge clock);
      if (i >= 1 && i <= 4) begin
        chk("stream_q", l2_qa, 16'(i - 1));
        chk("stream_v", l2_va, 1);
      end else begin
        chk("stream_v_idle", l2_va, 0);
      end
    end

    wr_a(3, 16'h0000, 2'b11); tick();
    wr_a(3, 16'h5555, 2'b11);
    address_b = 3; rden_b = 1;
    tick(); idle();
    @(negedge clock);
    chk("rdw_old", l1_qb, 16'h0000);
    address_b = 3; rden_b = 1; tick(); idle();
    @(negedge clock);
    chk("rdw_new", l1_qb, 16'h5555);
    tick();
    @(negedge clock);
    chk("rdw_new_l2", l2_qb, 16'h5555);

    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 7; k++) tick();
    reset = 1;
    #1;
    chk("mid_busy", l1_busy, 1);
    chk("mid_q", l1_qb | l2_qb, 16'h0000);
    chk("mid_v", {l1_va, l1_vb, l2_va, l2_vb}, 0);
    tick(); tick();
    reset = 0;
    count_busy("sweep2_len");
    address_a = 16; rden_a = 1; tick(); idle();
    @(negedge clock);
    chk("post_clear", l1_qa, 16'h0000);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
